// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction-fetch stage.
package otter_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    TRAP = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  // Bubble word a downstream consumer may substitute when IF_VALID is low.
  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

  // True when a fetch PC is misaligned or beyond the 2**(mem_width+2)-byte memory.
  function automatic logic fetch_pc_bad(input logic [31:0] pc, input int unsigned mem_width);
    return (pc[1:0] != 2'b00) || ((pc >> (mem_width + 2)) != 32'h0);
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Capture-enabled (pc, instr) register pair with an output mux that selects
// between the held pair and the live pair.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        sel_hold,
  input  logic [31:0] cap_pc,
  input  logic [31:0] cap_instr,
  input  logic [31:0] live_pc,
  input  logic [31:0] live_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  always_comb begin
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    if (capture) begin
      hold_pc_d    = cap_pc;
      hold_instr_d = cap_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_pc_q    <= 32'h0;
      hold_instr_q <= 32'h0;
    end else begin
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign out_pc    = sel_hold ? hold_pc_q    : live_pc;
  assign out_instr = sel_hold ? hold_instr_q : live_instr;

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch stage: owns the PC, drives memory port 1 and presents
// valid/PC/instruction to IF/ID. Optional macro OTTER_FETCH_TRAP_EN adds a TRAP state.
module otter_fetch_stage
  import otter_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WIDTH = 14
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] MEM_ADDR1,
  output logic        MEM_READ1,
  input  logic [31:0] MEM_DOUT1,
  output logic        IF_VALID,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTR,
  output logic        IF_ERR
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic         read_req;
  logic         capture;
  logic         trap_now;
  logic [31:0]  live_pc;
  logic [31:0]  live_instr;
  logic [31:0]  pc_next_seq;

  assign pc_next_seq = pc_q + 32'(INSTR_BYTES);

  assign IF_VALID   = (state_q == RUN) || (state_q == HOLD);
  assign live_pc    = (state_q == RUN) ? rsp_pc_q  : 32'h0;
  assign live_instr = (state_q == RUN) ? MEM_DOUT1 : 32'h0;

  fetch_hold_buf u_hold_buf (
    .clk        (CLK),
    .rst_n      (RST_N),
    .capture    (capture),
    .sel_hold   (state_q == HOLD),
    .cap_pc     (rsp_pc_q),
    .cap_instr  (MEM_DOUT1),
    .live_pc    (live_pc),
    .live_instr (live_instr),
    .out_pc     (IF_PC),
    .out_instr  (IF_INSTR)
  );

  assign IF_ERR = IF_VALID && fetch_pc_bad(IF_PC, MEM_WIDTH);

`ifdef OTTER_FETCH_TRAP_EN
  assign trap_now = IF_ERR;
`else
  assign trap_now = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    read_req = 1'b0;
    capture  = 1'b0;
    if (REDIRECT) begin
      pc_d    = REDIRECT_PC;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          read_req = 1'b1;
          pc_d     = pc_next_seq;
          rsp_pc_d = pc_q;
          state_d  = RUN;
        end
        RUN, HOLD: begin
          if (STALL) begin
            // Entering HOLD snapshots the live response; staying in HOLD keeps it.
            capture = (state_q == RUN);
            state_d = HOLD;
          end else if (trap_now) begin
            state_d = TRAP;
          end else begin
            read_req = 1'b1;
            pc_d     = pc_next_seq;
            rsp_pc_d = pc_q;
            state_d  = RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      rsp_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
    end
  end

  assign MEM_ADDR1 = pc_q;
  assign MEM_READ1 = read_req && RST_N;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Self-checking bench for otter_fetch_stage: directed scenarios then random
// stall/redirect/reset traffic against a stream-level reference model.
module tb_otter_fetch_stage;

  logic        CLK;
  logic        RST_N;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] MEM_ADDR1;
  logic        MEM_READ1;
  logic [31:0] MEM_DOUT1;
  logic        IF_VALID;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
  logic        IF_ERR;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: what the IF/ID boundary should present.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;

  otter_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WIDTH (14)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .STALL       (STALL),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .MEM_ADDR1   (MEM_ADDR1),
    .MEM_READ1   (MEM_READ1),
    .MEM_DOUT1   (MEM_DOUT1),
    .IF_VALID    (IF_VALID),
    .IF_PC       (IF_PC),
    .IF_INSTR    (IF_INSTR),
    .IF_ERR      (IF_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] tagOf(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  // Synchronous-read memory; when not read it drives garbage to expose any
  // reliance on the data port holding its value.
  always @(posedge CLK) begin
    if (MEM_READ1) MEM_DOUT1 <= tagOf(MEM_ADDR1);
    else           MEM_DOUT1 <= $urandom;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  function automatic logic pcBad(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc >= 32'h0001_0000);
  endfunction

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] target);
    logic        expRead;
    logic [31:0] expAddr;
    STALL       = stall;
    REDIRECT    = redir;
    REDIRECT_PC = target;
    #1;
    expRead = !redir && (!m_valid || !stall);
    expAddr = m_valid ? m_pc + 32'd4 : m_next;
    checkOutput("if_valid", 32'(IF_VALID), 32'(m_valid));
    checkOutput("if_pc",    IF_PC,    m_valid ? m_pc : 32'h0);
    checkOutput("if_instr", IF_INSTR, m_valid ? tagOf(m_pc) : 32'h0);
    checkOutput("if_err",   32'(IF_ERR), 32'(m_valid && pcBad(m_pc)));
    checkOutput("mem_read1", 32'(MEM_READ1), 32'(expRead));
    checkOutput("mem_addr1", MEM_ADDR1, expAddr);
    @(posedge CLK);
    if (redir) begin
      m_valid = 1'b0;
      m_next  = target;
    end else if (!m_valid) begin
      m_valid = 1'b1;
      m_pc    = m_next;
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
    @(negedge CLK);
  endtask

  task automatic applyReset();
    RST_N    = 1'b0;
    STALL    = 1'b0;
    REDIRECT = 1'b0;
    #1;
    checkOutput("rst_if_valid",  32'(IF_VALID),  32'h0);
    checkOutput("rst_if_pc",     IF_PC,          32'h0);
    checkOutput("rst_if_instr",  IF_INSTR,       32'h0);
    checkOutput("rst_if_err",    32'(IF_ERR),    32'h0);
    checkOutput("rst_mem_read1", 32'(MEM_READ1), 32'h0);
    checkOutput("rst_mem_addr1", MEM_ADDR1,      32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST_N   = 1'b1;
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_next  = 32'h0;
  endtask

  initial begin
    logic [31:0] tgt;
    RST_N       = 1'b0;
    STALL       = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 32'h0;
    m_valid     = 1'b0;
    m_pc        = 32'h0;
    m_next      = 32'h0;
    @(negedge CLK);
    applyReset();

    // Sequential fetch 0,4,8 then a 3-cycle stall at PC 8.
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    // Redirect while presenting PC 20.
    applyStimulus(1'b0, 1'b1, 32'h0000_0100);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    // Redirect together with stall while holding.
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0200);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    // Out-of-range, misaligned and wrapping targets.
    applyStimulus(1'b0, 1'b1, 32'h0001_0000);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0102);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    // Reset asserted in the middle of a stall.
    repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
    applyReset();
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom % 5)
        0:       tgt = 32'($urandom % 64) * 32'd4;
        1:       tgt = 32'h0000_FFF8;
        2:       tgt = 32'($urandom % 256) | 32'h1;
        3:       tgt = 32'hFFFF_FFF8;
        default: tgt = $urandom;
      endcase
      if ($urandom % 100 == 0) applyReset();
      else applyStimulus(($urandom % 10) < 3, ($urandom % 10) == 0, tgt);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
